// File: rtl/spikein_capture.sv
// Spike input capture: synchronises p_num asynchronous spike lines, detects rising edges,
// merges the edges seen in a p_window-cycle window into one vector and hands it off via valid/ready.
module spikein_capture #(
   parameter int p_num    = 10,
   parameter int p_window = 2,
   parameter int p_sync   = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_enable,
   input  logic [p_num-1:0] i_spike,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [p_num-1:0] o_spike,
   output logic             o_spike_in,
   output logic             o_busy,
   output logic             o_overflow
);

   localparam int CW = $clog2(p_window + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   state_t                       r_state;
   logic [p_sync-1:0][p_num-1:0] r_sync;
   logic [p_num-1:0]             r_dly;
   logic [p_num-1:0]             r_acc;
   logic [CW-1:0]                r_cnt;
   logic [p_num-1:0]             w_edge;
   logic                         w_any;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= '0;
         r_dly  <= '0;
      end else begin
         r_sync <= {r_sync[p_sync-2:0], i_spike};
         r_dly  <= r_sync[p_sync-1];
      end
   end

   assign w_edge = r_sync[p_sync-1] & ~r_dly;
   assign w_any  = |w_edge;
   assign o_busy = (r_state != IDLE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_acc      <= '0;
         r_cnt      <= '0;
         o_valid    <= 1'b0;
         o_spike    <= '0;
         o_spike_in <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         o_spike_in <= 1'b0;
         o_overflow <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_enable && w_any) begin
                  r_cnt <= CW'(1);
                  if (p_window == 1) begin
                     // single-cycle window: the first edge cycle is also the last
                     o_spike    <= w_edge;
                     o_valid    <= 1'b1;
                     o_spike_in <= 1'b1;
                     r_acc      <= '0;
                     r_state    <= HOLD;
                  end else begin
                     r_acc   <= w_edge;
                     r_state <= COLLECT;
                  end
               end
            end
            COLLECT: begin
               if (!i_enable) begin
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end else if (r_cnt == CW'(p_window - 1)) begin
                  o_spike    <= r_acc | w_edge;
                  o_valid    <= 1'b1;
                  o_spike_in <= 1'b1;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_state    <= HOLD;
               end else begin
                  r_acc <= r_acc | w_edge;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            HOLD: begin
               o_overflow <= w_any;
               if (o_valid && i_ready) begin
                  o_valid <= 1'b0;
                  o_spike <= '0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spikein_capture.sv
// Directed bench for spikein_capture: per-cycle vector table on a p_window=2 instance,
// plus hand sequences for reset in HOLD, a line held across reset and a p_window=1 instance.
module tb_spikein_capture;

   logic       clk = 1'b0;
   logic       rst, en, rdy;
   logic [9:0] spk;
   logic       valid, sin, busy, ovf;
   logic [9:0] osp;

   logic [9:0] w1_spk;
   logic       w1_en, w1_rdy;
   logic       w1_valid, w1_sin, w1_busy, w1_ovf;
   logic [9:0] w1_osp;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   spikein_capture #(.p_num(10), .p_window(2), .p_sync(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_spike(spk), .i_ready(rdy),
      .o_valid(valid), .o_spike(osp), .o_spike_in(sin), .o_busy(busy), .o_overflow(ovf)
   );

   spikein_capture #(.p_num(10), .p_window(1), .p_sync(2)) dut_w1 (
      .i_clk(clk), .i_rst(rst), .i_enable(w1_en), .i_spike(w1_spk), .i_ready(w1_rdy),
      .o_valid(w1_valid), .o_spike(w1_osp), .o_spike_in(w1_sin), .o_busy(w1_busy),
      .o_overflow(w1_ovf)
   );

   // er = {enable, ready}; fl = expected {valid, spike_in, busy, overflow} after the cycle
   typedef struct {
      logic [9:0] spike;
      logic [1:0] er;
      logic [9:0] osp;
      logic [3:0] fl;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input int idx, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, got, exp);
      end
   endtask

   task automatic chk_main(input string nm, input int idx, input logic [9:0] e_osp,
                           input logic [3:0] e_fl);
      chk({nm, ".valid"},    idx, 32'(valid), 32'(e_fl[3]));
      chk({nm, ".spike"},    idx, 32'(osp),   32'(e_osp));
      chk({nm, ".spike_in"}, idx, 32'(sin),   32'(e_fl[2]));
      chk({nm, ".busy"},     idx, 32'(busy),  32'(e_fl[1]));
      chk({nm, ".overflow"}, idx, 32'(ovf),   32'(e_fl[0]));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nsin, first, novf;

      // single event on bit 3
      tbl.push_back('{10'h008, 2'b11, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0010});
      tbl.push_back('{10'h000, 2'b11, 10'h008, 4'b1110});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0000});
      // bits 0,5 merged; bit 7 becomes a second event
      tbl.push_back('{10'h001, 2'b11, 10'h000, 4'b0000});
      tbl.push_back('{10'h020, 2'b11, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0010});
      tbl.push_back('{10'h080, 2'b11, 10'h021, 4'b1110});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0010});
      tbl.push_back('{10'h000, 2'b11, 10'h080, 4'b1110});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0000});
      // backpressure; bit 2 dropped in HOLD
      tbl.push_back('{10'h001, 2'b10, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b10, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b10, 10'h000, 4'b0010});
      tbl.push_back('{10'h000, 2'b10, 10'h001, 4'b1110});
      tbl.push_back('{10'h004, 2'b10, 10'h001, 4'b1010});
      tbl.push_back('{10'h000, 2'b10, 10'h001, 4'b1010});
      tbl.push_back('{10'h000, 2'b10, 10'h001, 4'b1011});
      tbl.push_back('{10'h000, 2'b10, 10'h001, 4'b1010});
      tbl.push_back('{10'h000, 2'b10, 10'h001, 4'b1010});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0000});
      // disabled: bit 1 ignored silently
      tbl.push_back('{10'h002, 2'b01, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b01, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b01, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b01, 10'h000, 4'b0000});
      // enable dropped in COLLECT
      tbl.push_back('{10'h010, 2'b11, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0010});
      tbl.push_back('{10'h000, 2'b01, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0000});
      tbl.push_back('{10'h000, 2'b11, 10'h000, 4'b0000});

      rst = 1'b1; en = 1'b1; rdy = 1'b1; spk = '0;
      w1_spk = '0; w1_en = 1'b1; w1_rdy = 1'b1;
      #1;
      step();
      step();
      chk_main("reset", 0, 10'h000, 4'b0000);
      chk("reset.w1_valid", 0, 32'(w1_valid), 32'd0);
      chk("reset.w1_busy",  0, 32'(w1_busy),  32'd0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         spk = tbl[i].spike;
         en  = tbl[i].er[1];
         rdy = tbl[i].er[0];
         step();
         chk_main("vec", i, tbl[i].osp, tbl[i].fl);
      end

      // reset while holding a vector
      en = 1'b1; rdy = 1'b0; spk = 10'h040;
      step();
      spk = '0;
      step();
      step();
      step();
      chk_main("pre_rst", 0, 10'h040, 4'b1110);
      step();
      chk_main("pre_rst", 1, 10'h040, 4'b1010);
      rst = 1'b1; spk = 10'h100;
      step();
      chk_main("rst_hold", 0, 10'h000, 4'b0000);
      rst = 1'b0; rdy = 1'b1;

      // bit 8 held high across reset: exactly one event, valid 3 cycles after release
      nsin = 0; first = -1;
      for (int k = 0; k < 12; k++) begin
         step();
         if (sin) nsin++;
         if (valid && first < 0) begin
            first = k;
            chk("held.spike", k, 32'(osp), 32'h100);
         end
      end
      chk("held.events", 0, 32'(nsin),  32'd1);
      chk("held.first",  0, 32'(first), 32'd3);
      spk = '0;

      // p_window=1: bit 9 held 10 cycles gives one event, valid one cycle after the edge
      nsin = 0; first = -1; novf = 0;
      for (int k = 0; k < 14; k++) begin
         w1_spk = (k < 10) ? 10'h200 : 10'h000;
         step();
         if (w1_sin) nsin++;
         if (w1_ovf) novf++;
         if (w1_valid && first < 0) begin
            first = k;
            chk("w1.spike", k, 32'(w1_osp), 32'h200);
         end
      end
      chk("w1.events",   0, 32'(nsin),     32'd1);
      chk("w1.first",    0, 32'(first),    32'd2);
      chk("w1.overflow", 0, 32'(novf),     32'd0);
      chk("w1.idle",     0, 32'(w1_busy),  32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spikein_capture.md
Name: spikein_capture

Overview:
- Receive-side counterpart of the delayed spike-out generator.
- Takes asynchronous spike pulses from p_num input lines, synchronises them and detects rising edges.
- Merges all edges that arrive within a fixed window after the first one into one event vector.
- Presents the vector with a valid/ready handshake, plus a single-cycle o_spike_in trigger suitable for driving a downstream spike-out generator's event input.

Parameters:
- p_num, 10, number of spike lines.
- p_window, 2, capture window length in clock cycles, counting the first-edge cycle; legal range 1..255.
- p_sync, 2, synchroniser depth per line; minimum 2.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_enable  input  1  arms capture; low blocks new events.
- i_spike  input  p_num  asynchronous spike lines.
- i_ready  input  1  downstream accepts the held vector.
- o_valid  output  1  held event vector is available.
- o_spike  output  p_num  merged event vector; stable while o_valid is high.
- o_spike_in  output  1  one-cycle pulse on the cycle o_valid first rises.
- o_busy  output  1  high whenever the state is not IDLE.
- o_overflow  output  1  one-cycle pulse when an edge is dropped.

Behaviour:
- Synchroniser and edge detect:
  - Each line passes through p_sync flops, then one more delay flop.
  - Edge vector: e = sync_out & ~sync_dly.
  - A line held high yields exactly one edge.
  - An input rising before clock edge t produces its edge in cycle t+p_sync.
- State machine, states IDLE, COLLECT, HOLD; counter width $clog2(p_window+1).
- IDLE:
  - If i_enable and |e: acc <= e, cnt <= 1.
  - Go to COLLECT, or to HOLD directly when p_window == 1.
- COLLECT:
  - Each cycle: acc <= acc | e, cnt <= cnt+1.
  - When cnt == p_window-1, that cycle's edges are ORed in, o_spike <= acc|e, o_valid <= 1, o_spike_in <= 1, then go to HOLD.
  - If i_enable drops during COLLECT, go to IDLE, clear acc, produce no output.
- HOLD:
  - o_valid and o_spike are held; o_spike_in is low after its first cycle.
  - Transfer occurs on a cycle with o_valid & i_ready. Next cycle: o_valid = 0, o_spike = 0, state IDLE.
  - i_enable is ignored in HOLD.
- Timing: first edge at cycle t0 gives o_valid high from t0+p_window. Edges in cycles t0 .. t0+p_window-1 are merged.
- Dropped edges:
  - Any edge arriving in HOLD, including the handshake cycle, is dropped.
  - o_overflow pulses once for each cycle that contains at least one dropped edge.
  - Edges while IDLE with i_enable low are ignored silently; no overflow.
- Re-arm: IDLE can start a new event on the cycle immediately after the transfer.
- Reset:
  - Clears all synchroniser and delay flops, acc, cnt and every output (all 0); state IDLE.
  - Reset mid-COLLECT or mid-HOLD discards the pending vector; no o_spike_in.
  - A line high during reset produces one edge p_sync+1 cycles after reset is released.

Test Plan:
- p_num=10, p_window=2, p_sync=2; pulse on bit 3 at cycle 0, i_ready=1 → o_valid and o_spike_in high at cycle 4, o_spike=0x008; o_valid low at cycle 5.
- Pulses on bits 0 and 5 one cycle apart, then bit 7 three cycles after bit 0 → first event o_spike=0x021; second event o_spike=0x080, with separate o_spike_in pulses.
- i_ready low for 6 cycles after o_valid; pulse on bit 2 during HOLD → o_overflow single pulse, o_spike unchanged; after i_ready=1, one transfer, then IDLE and no event for bit 2.
- i_enable=0 with pulse on bit 1 → no o_busy, no o_overflow. Drop i_enable in COLLECT → state returns to IDLE, o_valid stays 0.
- Assert i_rst during HOLD → next cycle all outputs 0 and o_busy=0. A line held high across the reset → exactly one event after release.
- p_window=1 with bit 9 held high for 10 cycles → exactly one event, o_spike=0x200, o_valid at edge cycle +1.
